// File: rtl/weight_pkg.sv
// Shared definitions for the weight stream loader: state/layer codes, per-layer
// word counts and the layer_id decoder.
package weight_pkg;

  localparam int unsigned L1_WEIGHTS   = 216;  // 72 rows x 3 lanes
  localparam int unsigned LMID_WEIGHTS = 576;  // 72 rows x 8 lanes
  localparam int unsigned L7_WEIGHTS   = 400;  // 50 rows x 8 lanes

  // The encoding is visible on weight_fsm_cs, so the values are fixed.
  typedef enum logic [3:0] {
    IDLE     = 4'b0000,
    L1_STORE = 4'b0001,
    L2_STORE = 4'b0010,
    L4_STORE = 4'b0011,
    L5_STORE = 4'b0100,
    L7_STORE = 4'b0101,
    FINISH   = 4'b1111
  } weight_state_e;

  typedef struct packed {
    logic          valid;
    weight_state_e code;
    logic [15:0]   total;
  } layer_info_t;

  function automatic layer_info_t decode_layer(input logic [2:0] layer_id);
    layer_info_t info;
    info.valid = 1'b1;
    info.code  = IDLE;
    info.total = '0;
    case (layer_id)
      3'd1: begin info.code = L1_STORE; info.total = 16'(L1_WEIGHTS);   end
      3'd2: begin info.code = L2_STORE; info.total = 16'(LMID_WEIGHTS); end
      3'd4: begin info.code = L4_STORE; info.total = 16'(LMID_WEIGHTS); end
      3'd5: begin info.code = L5_STORE; info.total = 16'(LMID_WEIGHTS); end
      3'd7: begin info.code = L7_STORE; info.total = 16'(L7_WEIGHTS);   end
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/counter_cnn.sv
// Clearable up-counter used as the element counter of the weight loader.
module counter_cnn #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/weight_stream_loader.sv
// Loads one layer of weights from a valid/ready stream into the local weight
// memory write port. Optional running checksum: WEIGHT_LOADER_CHECKSUM_EN.
module weight_stream_loader
  import weight_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  layer_id,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        write_weight_signal,
  output logic [15:0] write_weight_data,
  output logic [15:0] write_weight_addr,
  output logic [3:0]  weight_fsm_cs,
  output logic        weight_store_done,
  output logic        busy,
  output logic        layer_err
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  weight_state_e state_q, state_d;
  logic [15:0]   total_q, total_d;
  logic [15:0]   count;
  layer_info_t   info;
  logic          storing, start_ok, hs;
  logic          wr_sig_q, err_q;
  logic [15:0]   wr_data_q, wr_addr_q;

  assign info     = decode_layer(layer_id);
  assign storing  = state_q inside {L1_STORE, L2_STORE, L4_STORE, L5_STORE, L7_STORE};
  assign start_ok = (state_q == IDLE) && start && info.valid;
  assign in_ready = storing && (count < total_q);
  assign hs       = in_valid && in_ready;

  counter_cnn #(.WIDTH(16)) u_elem_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_ok),
    .inc_i   (hs),
    .count_o (count)
  );

  // NOTE: defaults first so every path assigns every output: no latches.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = info.code;
          total_d = info.total;
        end
      end
      L1_STORE, L2_STORE, L4_STORE, L5_STORE, L7_STORE: begin
        // The last write is already on the port when count reaches total.
        if (count == total_q) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      total_q   <= '0;
      wr_sig_q  <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      wr_sig_q <= hs;
      err_q    <= (state_q == IDLE) && start && !info.valid;
      if (hs) begin
        wr_data_q <= in_data;
        wr_addr_q <= count;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (hs) begin
      sum_q <= sum_q + in_data;
    end
  end

  assign checksum = sum_q;
`endif

  assign write_weight_signal = wr_sig_q;
  assign write_weight_data   = wr_data_q;
  assign write_weight_addr   = wr_addr_q;
  assign weight_fsm_cs       = state_q;
  assign weight_store_done   = (state_q == FINISH);
  assign busy                = (state_q != IDLE);
  assign layer_err           = err_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Randomized self-checking bench for weight_stream_loader; checksum checks are
// compiled in when WEIGHT_LOADER_CHECKSUM_EN is defined.
module tb_weight_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  layer_id;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        write_weight_signal;
  logic [15:0] write_weight_data;
  logic [15:0] write_weight_addr;
  logic [3:0]  weight_fsm_cs;
  logic        weight_store_done;
  logic        busy;
  logic        layer_err;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  weight_stream_loader dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .layer_id            (layer_id),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .write_weight_signal (write_weight_signal),
    .write_weight_data   (write_weight_data),
    .write_weight_addr   (write_weight_addr),
    .weight_fsm_cs       (weight_fsm_cs),
    .weight_store_done   (weight_store_done),
    .busy                (busy),
    .layer_err           (layer_err)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    .checksum            (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Observation record of one load, filled by run_stream.
  int          hs_cyc[$];
  logic [15:0] hs_dat[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_dat[$];
  logic [3:0]  wr_fsm[$];
  int          done_cyc[$];
  int          err_pulses;
  int          final_fsm;
  bit          timed_out;
  logic [15:0] chk_at_done;

  // Reference model: word count and store code of each layer.
  function automatic int exp_total(input int lid);
    case (lid)
      1:       return 216;
      2, 4, 5: return 576;
      7:       return 400;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_code(input int lid);
    case (lid)
      1: return 1;
      2: return 2;
      4: return 3;
      5: return 4;
      7: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] gen_word(input int dmode, input int idx);
    case (dmode)
      1:       return idx[15:0];
      2:       return 16'h0101;
      default: return 16'($urandom);
    endcase
  endfunction

  // vmode: 0 valid held high, 1 toggling, 2 random. dmode: 0 random, 1 ramp, 2 0x0101.
  task automatic run_stream(input logic [2:0] lid, input int vmode, input int dmode,
                            input int restart_word, input int abort_word);
    int cyc, sent;
    bit restarted, finished, saw_done;
    logic [15:0] cur;
    hs_cyc.delete(); hs_dat.delete(); wr_cyc.delete(); wr_addr.delete();
    wr_dat.delete(); wr_fsm.delete(); done_cyc.delete();
    err_pulses = 0; final_fsm = -1; timed_out = 0; chk_at_done = 'x;
    @(posedge clk); #1;
    start = 1'b1; layer_id = lid; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; sent = 0; restarted = 0; finished = 0; saw_done = 0;
    cur = gen_word(dmode, 0);
    while (!finished) begin
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = cur;
      if (restart_word >= 0 && !restarted && sent == restart_word) begin
        start = 1'b1; layer_id = 3'd5; restarted = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (write_weight_signal) begin
        wr_cyc.push_back(cyc); wr_addr.push_back(write_weight_addr);
        wr_dat.push_back(write_weight_data); wr_fsm.push_back(weight_fsm_cs);
      end
      if (layer_err) err_pulses++;
      if (saw_done) begin
        final_fsm = int'(weight_fsm_cs);
        finished  = 1;
      end
      if (weight_store_done) begin
        done_cyc.push_back(cyc);
        saw_done = 1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk_at_done = checksum;
`endif
      end
      if (in_valid && in_ready) begin
        hs_cyc.push_back(cyc); hs_dat.push_back(in_data);
        sent++;
        cur = gen_word(dmode, sent);
      end
      if (abort_word >= 0 && sent == abort_word) begin
        rst = 1'b0;
        #1;
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; layer_id = '0; in_valid = 1'b0; in_data = '0;
    #2;
    n_vec++;
    if ({in_ready, write_weight_signal, write_weight_data, write_weight_addr,
         weight_fsm_cs, weight_store_done, busy, layer_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b data=%h addr=%h cs=%b done=%b busy=%b err=%b, want all zero",
               in_ready, write_weight_signal, write_weight_data, write_weight_addr,
               weight_fsm_cs, weight_store_done, busy, layer_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_layer1_full_rate();
    run_stream(3'd1, 0, 0, -1, -1);
    n_vec++;
    if (timed_out || wr_addr.size() != 216 || hs_cyc.size() != 216) begin
      n_fail++;
      $display("FAIL l1_count: got %0d writes %0d handshakes timeout=%0d, want 216 216 0",
               wr_addr.size(), hs_cyc.size(), timed_out);
    end
    for (int i = 0; i < wr_addr.size() && i < hs_cyc.size(); i++) begin
      n_vec++;
      if (wr_addr[i] !== 16'(i) || wr_dat[i] !== hs_dat[i] || wr_cyc[i] != i + 1 ||
          hs_cyc[i] != i || wr_fsm[i] !== 4'(exp_code(1))) begin
        n_fail++;
        $display("FAIL l1_write[%0d]: got addr=%0d data=%h cyc=%0d cs=%b, want addr=%0d data=%h cyc=%0d cs=%b",
                 i, wr_addr[i], wr_dat[i], wr_cyc[i], wr_fsm[i], i, hs_dat[i], i + 1, 4'(exp_code(1)));
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || wr_cyc.size() == 0 || done_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
      n_fail++;
      $display("FAIL l1_done: got %0d pulses first at %0d, want 1 pulse at %0d",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, 217);
    end
    n_vec++;
    if (final_fsm != 0 || err_pulses != 0) begin
      n_fail++;
      $display("FAIL l1_after: got cs=%0d err_pulses=%0d, want 0 0", final_fsm, err_pulses);
    end
  endtask

  task automatic test_layer7_toggle_ramp();
    run_stream(3'd7, 1, 1, -1, -1);
    n_vec++;
    if (timed_out || wr_addr.size() != exp_total(7) || hs_cyc.size() != exp_total(7)) begin
      n_fail++;
      $display("FAIL l7_count: got %0d writes %0d handshakes, want %0d", wr_addr.size(), hs_cyc.size(), exp_total(7));
    end
    for (int i = 0; i < wr_addr.size() && i < hs_cyc.size(); i++) begin
      n_vec++;
      if (wr_addr[i] !== 16'(i) || wr_dat[i] !== 16'(i) || wr_cyc[i] != hs_cyc[i] + 1 ||
          wr_fsm[i] !== 4'(exp_code(7))) begin
        n_fail++;
        $display("FAIL l7_write[%0d]: got addr=%0d data=%h cyc=%0d cs=%b, want addr=%0d data=%h cyc=%0d cs=%b",
                 i, wr_addr[i], wr_dat[i], wr_cyc[i], wr_fsm[i], i, 16'(i), hs_cyc[i] + 1, 4'(exp_code(7)));
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || final_fsm != 0) begin
      n_fail++;
      $display("FAIL l7_done: got %0d pulses final cs=%0d, want 1 pulse then 0", done_cyc.size(), final_fsm);
    end
  endtask

  task automatic test_bad_layer();
    int lids[3] = '{0, 3, 6};
    foreach (lids[k]) begin
      int errs, first_err, busy_seen, wr_seen, rdy_seen;
      errs = 0; first_err = -1; busy_seen = 0; wr_seen = 0; rdy_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; layer_id = 3'(lids[k]); in_valid = 1'b1; in_data = 16'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (layer_err) begin
          errs++;
          if (first_err < 0) first_err = c;
        end
        busy_seen += int'(busy);
        wr_seen   += int'(write_weight_signal);
        rdy_seen  += int'(in_ready);
      end
      in_valid = 1'b0;
      n_vec++;
      if (errs != 1 || first_err != 0) begin
        n_fail++;
        $display("FAIL bad_layer_err[%0d]: got %0d pulses first at %0d, want 1 at 0", lids[k], errs, first_err);
      end
      n_vec++;
      if (busy_seen != 0 || wr_seen != 0 || rdy_seen != 0) begin
        n_fail++;
        $display("FAIL bad_layer_idle[%0d]: got busy=%0d writes=%0d ready=%0d cycles, want 0 0 0",
                 lids[k], busy_seen, wr_seen, rdy_seen);
      end
    end
  endtask

  task automatic test_restart_ignored();
    run_stream(3'd2, 2, 0, 100, -1);
    n_vec++;
    if (timed_out || wr_addr.size() != exp_total(2) || hs_cyc.size() != exp_total(2)) begin
      n_fail++;
      $display("FAIL restart_count: got %0d writes %0d handshakes, want %0d", wr_addr.size(), hs_cyc.size(), exp_total(2));
    end
    for (int i = 0; i < wr_addr.size() && i < hs_cyc.size(); i++) begin
      n_vec++;
      if (wr_addr[i] !== 16'(i) || wr_dat[i] !== hs_dat[i] || wr_fsm[i] !== 4'(exp_code(2))) begin
        n_fail++;
        $display("FAIL restart_write[%0d]: got addr=%0d data=%h cs=%b, want addr=%0d data=%h cs=%b",
                 i, wr_addr[i], wr_dat[i], wr_fsm[i], i, hs_dat[i], 4'(exp_code(2)));
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || final_fsm != 0 || err_pulses != 0) begin
      n_fail++;
      $display("FAIL restart_end: got %0d done pulses final cs=%0d err=%0d, want 1 0 0",
               done_cyc.size(), final_fsm, err_pulses);
    end
  endtask

  task automatic test_reset_midload();
    run_stream(3'd4, 0, 0, -1, 300);
    n_vec++;
    if (hs_cyc.size() != 300 || {in_ready, write_weight_signal, write_weight_data, write_weight_addr,
         weight_fsm_cs, weight_store_done, busy, layer_err} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: got hs=%0d rdy=%b wr=%b data=%h addr=%h cs=%b done=%b busy=%b err=%b, want 300 and all zero",
               hs_cyc.size(), in_ready, write_weight_signal, write_weight_data, write_weight_addr,
               weight_fsm_cs, weight_store_done, busy, layer_err);
    end
    @(negedge clk);
    rst = 1'b1;
    run_stream(3'd4, 2, 0, -1, -1);
    n_vec++;
    if (timed_out || wr_addr.size() != exp_total(4)) begin
      n_fail++;
      $display("FAIL reload_count: got %0d writes, want %0d", wr_addr.size(), exp_total(4));
    end
    for (int i = 0; i < wr_addr.size() && i < hs_dat.size(); i++) begin
      n_vec++;
      if (wr_addr[i] !== 16'(i) || wr_dat[i] !== hs_dat[i] || wr_fsm[i] !== 4'(exp_code(4))) begin
        n_fail++;
        $display("FAIL reload_write[%0d]: got addr=%0d data=%h cs=%b, want addr=%0d data=%h cs=%b",
                 i, wr_addr[i], wr_dat[i], wr_fsm[i], i, hs_dat[i], 4'(exp_code(4)));
      end
    end
    n_vec++;
    if (done_cyc.size() != 1 || final_fsm != 0) begin
      n_fail++;
      $display("FAIL reload_done: got %0d pulses final cs=%0d, want 1 then 0", done_cyc.size(), final_fsm);
    end
  endtask

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [15:0] sum;
    run_stream(3'd1, 2, 2, -1, -1);
    n_vec++;
    if (chk_at_done !== 16'hD8D8) begin
      n_fail++;
      $display("FAIL checksum_const: got %h, want d8d8", chk_at_done);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (checksum !== 16'hD8D8) begin
      n_fail++;
      $display("FAIL checksum_hold: got %h, want d8d8", checksum);
    end
    run_stream(3'd7, 2, 0, -1, -1);
    sum = '0;
    foreach (hs_dat[i]) sum += hs_dat[i];
    n_vec++;
    if (chk_at_done !== sum) begin
      n_fail++;
      $display("FAIL checksum_random: got %h, want %h", chk_at_done, sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_layer1_full_rate();
    test_layer7_toggle_ramp();
    test_bad_layer();
    test_restart_ignored();
    test_reset_midload();
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
